// File: rtl/status_glyph.sv
// status_glyph: 8x8 status-symbol overlay, integer up-scaled, fixed 3-clock pixel pipeline.
// Build option: define STATUS_GLYPH_BLINK_EN to blink the glyph for BLINK_FRAMES frames after a state change.
module status_glyph #(
   parameter int unsigned NUM_STATES   = 4,
   parameter int unsigned STATE_W      = 3,
   parameter int unsigned X_POS        = 400,
   parameter int unsigned Y_POS        = 200,
   parameter int unsigned SCALE_LOG2   = 1,
   parameter logic [23:0] COLOR        = 24'h00FFFF,
   parameter int unsigned BLINK_FRAMES = 48,
   parameter int unsigned BLINK_BIT    = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid,
   input  logic [STATE_W-1:0]      state,
   input  logic [9*NUM_STATES-1:0] glyph_addrs,
   input  logic [10:0]             vga_x,
   input  logic [9:0]              vga_y,
   output logic [8:0]              rom_addr,
   input  logic [7:0]              rom_data,
   output logic [7:0]              r,
   output logic [7:0]              g,
   output logic [7:0]              b,
   output logic                    valid_px
);

   localparam int unsigned      BOX    = 8 << SCALE_LOG2;
   localparam logic [11:0]      X_LO   = 12'(X_POS);
   localparam logic [11:0]      X_HI   = 12'(X_POS + BOX);
   localparam logic [11:0]      Y_LO   = 12'(Y_POS);
   localparam logic [11:0]      Y_HI   = 12'(Y_POS + BOX);
   localparam logic [STATE_W:0] NUM_ST = (STATE_W + 1)'(NUM_STATES);

   if (NUM_STATES < 2 || NUM_STATES > 8 || SCALE_LOG2 > 3 || BLINK_FRAMES < 1 ||
       BLINK_FRAMES > 255 || BLINK_BIT > 7 || (1 << STATE_W) < NUM_STATES) begin : g_bad_params
      $error("status_glyph: parameter out of range");
   end

   logic               fs;
   logic [STATE_W-1:0] disp_state;
   logic [STATE_W-1:0] next_disp;
   logic [8:0]         base;
   logic [11:0]        x12, y12, dx, dy;
   logic               hit0;
   logic [2:0]         col0, row0;
   logic               show;
   logic               hit1, show1, hit2, show2;
   logic [2:0]         col1, col2;
   logic               lit2;

   always_comb begin
      fs        = valid && (vga_x == '0) && (vga_y == '0);
      next_disp = ({1'b0, state} >= NUM_ST) ? '0 : state;
   end

   always_comb begin
      base = '0;
      for (int unsigned i = 0; i < NUM_STATES; i++)
         if (disp_state == STATE_W'(i)) base = glyph_addrs[9*i +: 9];
   end

   // 12-bit compare keeps the box from wrapping past the right/bottom edge.
   always_comb begin
      x12  = {1'b0, vga_x};
      y12  = {2'b0, vga_y};
      dx   = x12 - X_LO;
      dy   = y12 - Y_LO;
      hit0 = valid && (x12 >= X_LO) && (x12 < X_HI) && (y12 >= Y_LO) && (y12 < Y_HI);
      col0 = 3'(dx >> SCALE_LOG2);
      row0 = 3'(dy >> SCALE_LOG2);
   end

`ifdef STATUS_GLYPH_BLINK_EN
   logic [7:0] blink_cnt;

   // Only moves on frame start, so visibility is constant across a frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt <= '0;
      end else if (fs) begin
         if (next_disp != disp_state)
            blink_cnt <= 8'(BLINK_FRAMES);
         else if (blink_cnt != '0)
            blink_cnt <= blink_cnt - 8'd1;
      end
   end

   always_comb show = (blink_cnt == '0) || !blink_cnt[BLINK_BIT];
`else
   always_comb show = 1'b1;
`endif

   always_comb lit2 = hit2 && rom_data[3'd7 - col2] && show2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_state <= '0;
         rom_addr   <= '0;
         hit1       <= 1'b0;
         col1       <= '0;
         show1      <= 1'b0;
         hit2       <= 1'b0;
         col2       <= '0;
         show2      <= 1'b0;
         valid_px   <= 1'b0;
         r          <= '0;
         g          <= '0;
         b          <= '0;
      end else begin
         if (fs) disp_state <= next_disp;
         rom_addr <= base + {6'b0, row0};
         hit1     <= hit0;
         col1     <= col0;
         show1    <= show;
         hit2     <= hit1;
         col2     <= col1;
         show2    <= show1;
         valid_px <= lit2;
         r        <= lit2 ? COLOR[23:16] : '0;
         g        <= lit2 ? COLOR[15:8]  : '0;
         b        <= lit2 ? COLOR[7:0]   : '0;
      end
   end

endmodule

// File: tb/tb_status_glyph.sv
// tb_status_glyph: directed, table-driven bench for status_glyph with a synchronous ROM model.
// Expected visibility follows STATUS_GLYPH_BLINK_EN when the bench is built with the same define.
module tb_status_glyph;

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic        v;
      logic        chk_addr;
      logic [8:0]  addr;
      logic        lit;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [2:0]  state;
   logic [35:0] glyph_addrs;
   logic [10:0] vga_x;
   logic [9:0]  vga_y;
   logic [8:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  r, g, b;
   logic        valid_px;

   logic [7:0]  rom [512];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [2:0]  m_disp;
   logic [7:0]  m_cnt;
   vec_t        tbl [13];

   always #5 clk = ~clk;

   status_glyph #(
      .NUM_STATES(4), .STATE_W(3), .X_POS(400), .Y_POS(200), .SCALE_LOG2(1),
      .COLOR(24'h00FFFF), .BLINK_FRAMES(48), .BLINK_BIT(3)
   ) dut (
      .clk(clk), .reset(reset), .valid(valid), .state(state), .glyph_addrs(glyph_addrs),
      .vga_x(vga_x), .vga_y(vga_y), .rom_addr(rom_addr), .rom_data(rom_data),
      .r(r), .g(g), .b(b), .valid_px(valid_px)
   );

   always @(posedge clk) rom_data <= rom[rom_addr];

   function automatic vec_t mk(input int x, input int y, input bit v, input bit ca,
                               input int addr, input bit lit);
      vec_t t;
      t.x = 11'(x); t.y = 10'(y); t.v = v; t.chk_addr = ca; t.addr = 9'(addr); t.lit = lit;
      return t;
   endfunction

   function automatic logic m_show();
`ifdef STATUS_GLYPH_BLINK_EN
      return (m_cnt == 8'd0) || !m_cnt[3];
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [31:0] exp_px(input logic lit);
      return lit ? 32'h0100FFFF : 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      valid = 1'b0; vga_x = 11'd700; vga_y = 10'd500;
   endtask

   task automatic frame_start(input logic [2:0] st);
      logic [2:0] nd;
      @(negedge clk);
      state = st; vga_x = '0; vga_y = '0; valid = 1'b1;
      @(posedge clk);
      nd = (st >= 3'd4) ? 3'd0 : st;
      if (nd != m_disp) m_cnt = 8'd48;
      else if (m_cnt != 8'd0) m_cnt = m_cnt - 8'd1;
      m_disp = nd;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      vga_x = v.x; vga_y = v.y; valid = v.v;
      @(posedge clk); #1;
      if (v.chk_addr) check({tag, "_addr"}, 32'(rom_addr), 32'(v.addr));
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      @(posedge clk); #1;
      check({tag, "_px"}, {7'b0, valid_px, r, g, b}, exp_px(v.lit && m_show()));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      glyph_addrs = {9'h1FC, 9'h100, 9'h000, 9'h008};
      for (int i = 0; i < 512; i++) rom[i] = 8'h00;
      rom[9'h008] = 8'h81;
      rom[9'h009] = 8'h20;
      rom[9'h00F] = 8'h81;
      rom[9'h000] = 8'h40;
      rom[9'h100] = 8'hFF;
      rom[9'h1FC] = 8'hFF;

      tbl[0]  = mk(400, 200, 1, 1, 'h008, 1);
      tbl[1]  = mk(401, 201, 1, 1, 'h008, 1);
      tbl[2]  = mk(402, 200, 1, 1, 'h008, 0);
      tbl[3]  = mk(414, 214, 1, 1, 'h00F, 1);
      tbl[4]  = mk(415, 215, 1, 1, 'h00F, 1);
      tbl[5]  = mk(400, 215, 1, 1, 'h00F, 1);
      tbl[6]  = mk(404, 203, 1, 1, 'h009, 1);
      tbl[7]  = mk(406, 203, 1, 1, 'h009, 0);
      tbl[8]  = mk(399, 200, 1, 0, 0, 0);
      tbl[9]  = mk(416, 215, 1, 0, 0, 0);
      tbl[10] = mk(400, 216, 1, 0, 0, 0);
      tbl[11] = mk(400, 199, 1, 0, 0, 0);
      tbl[12] = mk(400, 200, 0, 1, 'h008, 0);

      reset = 1'b0; state = 3'd0; m_disp = 3'd0; m_cnt = 8'd0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      check("reset_px", {7'b0, valid_px, r, g, b}, 32'h0);
      check("reset_addr", 32'(rom_addr), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Entry 0 geometry, edges of the scaled box and valid gating.
      frame_start(3'd0);
      for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // State change mid-frame must wait for the next frame start.
      @(negedge clk);
      state = 3'd1;
      apply(mk(400, 200, 1, 1, 'h008, 1), "midframe_old");
      frame_start(3'd1);
      apply(mk(400, 200, 1, 1, 'h000, 0), "entry1_c0");
      apply(mk(402, 200, 1, 1, 'h000, 1), "entry1_c1");

      // Out-of-range state falls back to entry 0.
      frame_start(3'd5);
      apply(mk(400, 200, 1, 1, 'h008, 1), "clamp_r0");
      apply(mk(404, 203, 1, 1, 'h009, 1), "clamp_r1");

      // Base + row wraps modulo 512.
      frame_start(3'd3);
      apply(mk(400, 200, 1, 1, 'h1FC, 1), "entry3_r0");
      apply(mk(402, 208, 1, 1, 'h000, 1), "wrap_lit");
      apply(mk(400, 208, 1, 1, 'h000, 0), "wrap_unlit");

      // Blink cadence, with a second change at frame 20 reloading the counter.
      for (int k = 1; k <= 70; k++) begin
         logic [2:0] st;
         st = (k < 20) ? 3'd2 : 3'd0;
         frame_start(st);
         apply(mk(400, 200, 1, 1, (st == 3'd2) ? 'h100 : 'h008, 1), $sformatf("blink_f%0d", k));
      end

      // Asynchronous reset in the middle of the box.
      @(negedge clk);
      vga_x = 11'd404; vga_y = 10'd203; valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_px", {7'b0, valid_px, r, g, b}, exp_px(m_show()));
      #2;
      reset = 1'b0;
      m_disp = 3'd0; m_cnt = 8'd0;
      #1;
      check("async_reset_px", {7'b0, valid_px, r, g, b}, 32'h0);
      check("async_reset_addr", 32'(rom_addr), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_reset_e0_px", {7'b0, valid_px, r, g, b}, 32'h0);
      check("post_reset_e0_addr", 32'(rom_addr), 32'h009);
      @(posedge clk); #1;
      check("post_reset_e1_px", {7'b0, valid_px, r, g, b}, 32'h0);
      @(posedge clk); #1;
      check("post_reset_e2_px", {7'b0, valid_px, r, g, b}, exp_px(1'b1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
